// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle for the shared register arbiter: four requesters' write requests,
// the shared register view, and the grant/ack handshake.
interface shared_reg_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [3:0]         req;
   logic [4*WIDTH-1:0] wdata;
   logic               clr;
   logic [3:0]         grant;
   logic [3:0]         ack;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   qbar;
   logic               busy;
   logic [1:0]         last_id;
   logic [7:0]         wr_count;

   modport master (
      output req, wdata, clr,
      input  grant, ack, q, qbar, busy, last_id, wr_count
   );

   modport slave (
      input  req, wdata, clr,
      output grant, ack, q, qbar, busy, last_id, wr_count
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one of four requesters a write to a shared register.
//
// state | meaning
// IDLE  | waiting; clr clears q, otherwise a nonzero req picks a round-robin winner
// GRANT | grant[winner] high; write lands at the edge if req[winner] is still high
// ACK   | ack[winner] high for one cycle, q holds the new value
module shared_reg_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   shared_reg_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       ptr;
   logic [1:0]       winner;
   logic [1:0]       rr_idx;
   logic [1:0]       rr_cand;
   logic             rr_hit;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] wsel;
   logic [1:0]       last_id_r;
   logic [7:0]       wr_count_r;
   logic             load_winner;
   logic             do_write;
   logic             do_clr;

   // First set req bit found walking upward from ptr, modulo 4.
   always_comb begin
      rr_hit  = 1'b0;
      rr_idx  = ptr;
      rr_cand = ptr;
      for (int k = 0; k < 4; k++) begin
         rr_cand = ptr + 2'(k);
         if (!rr_hit && bus.req[rr_cand]) begin
            rr_hit = 1'b1;
            rr_idx = rr_cand;
         end
      end
   end

   assign wsel = bus.wdata[int'(winner)*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      load_winner = 1'b0;
      do_write    = 1'b0;
      do_clr      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clr) begin
               do_clr = 1'b1;
            end else if (rr_hit) begin
               load_winner = 1'b1;
               state_nxt   = GRANT;
            end
         end
         GRANT: begin
            if (bus.req[winner]) begin
               do_write  = 1'b1;
               state_nxt = ACK;
            end else begin
               state_nxt = IDLE;
            end
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr        <= 2'd0;
         winner     <= 2'd0;
         q_r        <= '0;
         last_id_r  <= 2'd0;
         wr_count_r <= 8'd0;
      end else begin
         if (load_winner) begin
            winner <= rr_idx;
         end
         if (do_clr) begin
            q_r <= '0;
         end else if (do_write) begin
            q_r        <= wsel;
            last_id_r  <= winner;
            wr_count_r <= wr_count_r + 8'd1;
            ptr        <= winner + 2'd1;
         end
      end
   end

   // Handshake outputs decode straight from state so an async reset drops them at once.
   assign bus.grant    = (state == GRANT) ? (4'b0001 << winner) : 4'b0000;
   assign bus.ack      = (state == ACK)   ? (4'b0001 << winner) : 4'b0000;
   assign bus.busy     = (state != IDLE);
   assign bus.q        = q_r;
   assign bus.qbar     = ~q_r;
   assign bus.last_id  = last_id_r;
   assign bus.wr_count = wr_count_r;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.grant));
   a_ack_onehot0   : assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.ack));
   a_grant_ack_exc : assert property (@(posedge clk) disable iff (!rst) !((|bus.grant) && (|bus.ack)));

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized self-checking bench for shared_reg_arbiter against a transaction-level model.
module tb_shared_reg_arbiter;
   localparam int W = 8;

   logic clk;
   logic rst;

   shared_reg_arbiter_if #(.WIDTH(W)) bus ();

   shared_reg_arbiter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Transaction-level model of the shared register.
   logic [W-1:0] m_q;
   logic [1:0]   m_last;
   logic [7:0]   m_cnt;
   int           m_ptr;

   function automatic logic [1:0] rr(input int p, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return 2'((p + k) % 4);
      end
      return 2'(p);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_q    = '0;
      m_last = 2'd0;
      m_cnt  = 8'd0;
      m_ptr  = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req = 4'b0000;
      bus.clr = 1'b0;
      #3;
      model_reset();
      n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
      n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
      n_checks++; if (bus.q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", bus.q); end
      n_checks++; if (bus.qbar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar got %h want ff", bus.qbar); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_checks++; if (bus.last_id !== 2'd0) begin n_fail++; $display("FAIL reset_last_id got %0d want 0", bus.last_id); end
      n_checks++; if (bus.wr_count !== 8'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d want 0", bus.wr_count); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Caller leaves the DUT idle with bus.req nonzero and clr low.
   task automatic run_txn(input bit abort, input bit clr_mid);
      logic [1:0]   w;
      logic [3:0]   exp_g;
      logic [W-1:0] d;
      w     = rr(m_ptr, bus.req);
      exp_g = 4'b0001 << w;
      d     = bus.wdata[int'(w)*W +: W];
      tick();
      n_checks++; if (bus.grant !== exp_g) begin n_fail++; $display("FAIL grant got %b want %b", bus.grant, exp_g); end
      n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL ack_in_grant got %b want 0000", bus.ack); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_grant got %b want 1", bus.busy); end
      bus.clr = clr_mid;
      if (abort) begin
         bus.req[w] = 1'b0;
         tick();
         bus.clr = 1'b0;
         n_checks++; if (bus.grant !== 4'b0000 || bus.ack !== 4'b0000) begin n_fail++; $display("FAIL abort_handshake got grant %b ack %b want 0000 0000", bus.grant, bus.ack); end
         n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
         n_checks++; if (bus.q !== m_q) begin n_fail++; $display("FAIL abort_q got %h want %h", bus.q, m_q); end
         n_checks++; if (bus.wr_count !== m_cnt) begin n_fail++; $display("FAIL abort_wr_count got %0d want %0d", bus.wr_count, m_cnt); end
         n_checks++; if (bus.last_id !== m_last) begin n_fail++; $display("FAIL abort_last_id got %0d want %0d", bus.last_id, m_last); end
      end else begin
         tick();
         m_q    = d;
         m_last = w;
         m_cnt  = m_cnt + 8'd1;
         m_ptr  = (int'(w) + 1) % 4;
         n_checks++; if (bus.ack !== exp_g) begin n_fail++; $display("FAIL ack got %b want %b", bus.ack, exp_g); end
         n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL grant_in_ack got %b want 0000", bus.grant); end
         n_checks++; if (bus.q !== m_q) begin n_fail++; $display("FAIL q got %h want %h", bus.q, m_q); end
         n_checks++; if (bus.qbar !== ~m_q) begin n_fail++; $display("FAIL qbar got %h want %h", bus.qbar, ~m_q); end
         n_checks++; if (bus.last_id !== m_last) begin n_fail++; $display("FAIL last_id got %0d want %0d", bus.last_id, m_last); end
         n_checks++; if (bus.wr_count !== m_cnt) begin n_fail++; $display("FAIL wr_count got %0d want %0d", bus.wr_count, m_cnt); end
         bus.req[w] = 1'b0;
         tick();
         bus.clr = 1'b0;
         n_checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_ack got ack %b busy %b want 0000 0", bus.ack, bus.busy); end
         n_checks++; if (bus.q !== m_q) begin n_fail++; $display("FAIL post_ack_q got %h want %h", bus.q, m_q); end
      end
   endtask

   task automatic test_basic();
      bus.wdata = '0;
      bus.wdata[7:0] = 8'hA5;
      bus.req = 4'b0001;
      run_txn(1'b0, 1'b0);
      n_checks++; if (bus.q !== 8'hA5 || bus.qbar !== 8'h5A) begin n_fail++; $display("FAIL basic_q got %h/%h want a5/5a", bus.q, bus.qbar); end
   endtask

   task automatic test_round_robin();
      test_reset();
      bus.wdata = {$urandom, $urandom};
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) run_txn(1'b0, 1'b0);
      n_checks++; if (bus.q !== bus.wdata[31:24]) begin n_fail++; $display("FAIL rr_final_q got %h want %h", bus.q, bus.wdata[31:24]); end
      n_checks++; if (bus.wr_count !== 8'd4) begin n_fail++; $display("FAIL rr_wr_count got %0d want 4", bus.wr_count); end
   endtask

   task automatic test_wrap_ptr();
      test_reset();
      bus.wdata = {$urandom, $urandom};
      bus.req = 4'b0100;
      run_txn(1'b0, 1'b0);
      bus.req = 4'b0101;
      run_txn(1'b0, 1'b0);
      n_checks++; if (bus.last_id !== 2'd0) begin n_fail++; $display("FAIL ptr_wrap_first got %0d want 0", bus.last_id); end
      run_txn(1'b0, 1'b0);
      n_checks++; if (bus.last_id !== 2'd2) begin n_fail++; $display("FAIL ptr_wrap_second got %0d want 2", bus.last_id); end
   endtask

   task automatic test_clr(input logic [3:0] r);
      bus.wdata = {$urandom, $urandom};
      bus.clr = 1'b1;
      bus.req = r;
      tick();
      m_q = '0;
      n_checks++; if (bus.q !== 8'h00 || bus.qbar !== 8'hFF) begin n_fail++; $display("FAIL clr_q got %h/%h want 00/ff", bus.q, bus.qbar); end
      n_checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_no_grant got grant %b busy %b want 0000 0", bus.grant, bus.busy); end
      n_checks++; if (bus.wr_count !== m_cnt) begin n_fail++; $display("FAIL clr_wr_count got %0d want %0d", bus.wr_count, m_cnt); end
      bus.clr = 1'b0;
      run_txn(1'b0, 1'b0);
   endtask

   task automatic test_abort();
      bus.wdata = {$urandom, $urandom};
      bus.req = 4'b0010;
      run_txn(1'b1, 1'b0);
      bus.req = 4'b0000;
   endtask

   task automatic test_reset_in_ack();
      bus.wdata = {$urandom, $urandom};
      bus.req = 4'b0001;
      tick();
      tick();
      n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL rst_ack_pre got %b want 0001", bus.ack); end
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      n_checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_in_ack got ack %b busy %b want 0000 0", bus.ack, bus.busy); end
      n_checks++; if (bus.q !== 8'h00 || bus.wr_count !== 8'd0) begin n_fail++; $display("FAIL rst_in_ack_state got q %h cnt %0d want 00 0", bus.q, bus.wr_count); end
      bus.req = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      tick();
      n_checks++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rst_release_idle got busy %b grant %b want 0 0000", bus.busy, bus.grant); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         bus.wdata = {$urandom, $urandom};
         if ($urandom_range(0, 5) == 0) begin
            test_clr(4'($urandom_range(1, 15)));
         end else begin
            bus.req = 4'($urandom_range(1, 15));
            run_txn($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
         end
      end
      bus.req = 4'b0000;
   endtask

   task automatic test_wr_count_wrap();
      test_reset();
      for (int i = 0; i < 256; i++) begin
         bus.wdata = {$urandom, $urandom};
         bus.req = 4'b0001;
         run_txn(1'b0, 1'b0);
      end
      n_checks++; if (bus.wr_count !== 8'd0) begin n_fail++; $display("FAIL wr_count_wrap got %0d want 0", bus.wr_count); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req   = 4'b0000;
      bus.wdata = '0;
      bus.clr   = 1'b0;
      rst       = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_round_robin();
      test_wrap_ptr();
      test_clr(4'b0010);
      test_abort();
      test_reset_in_ack();
      test_random();
      test_wr_count_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared register.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserted (0) forces reset state immediately, independent of clk.
REQ-004 req  input  4  per-requester write request; bit i = requester i.
REQ-005 wdata  input  4*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-006 clr  input  1  synchronous clear request for the shared register.
REQ-007 grant  output  4  one-hot grant, or all-zero.
REQ-008 ack  output  4  one-hot, one-cycle write-complete pulse, or all-zero.
REQ-009 q  output  WIDTH  shared register value.
REQ-010 qbar  output  WIDTH  bitwise complement of q, always.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 last_id  output  2  index of the most recent requester that completed a write.
REQ-013 wr_count  output  8  count of completed writes.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, GRANT and ACK, all registered.
REQ-015 IDLE with clr=1: at the edge, q <= 0, qbar <= all ones, stay IDLE; clr takes priority over req; no grant, no ack, wr_count unchanged.
REQ-016 IDLE with clr=0 and req!=0: at the edge, select a winner by round-robin and go to GRANT.
REQ-017 Round-robin: search starts at index ptr, upward modulo 4; first set req bit wins; ptr resets to 0.
REQ-018 GRANT: grant[winner]=1 for exactly one cycle; the requester SHALL hold wdata stable during this cycle.
REQ-019 GRANT with req[winner]=1 at the edge: q <= wdata[winner], qbar <= ~wdata[winner], last_id <= winner, wr_count <= wr_count+1 (wraps 255 -> 0), ptr <= (winner+1) mod 4, go to ACK.
REQ-020 GRANT with req[winner]=0 at the edge (abort): no write, ptr/last_id/wr_count unchanged, no ack, go to IDLE.
REQ-021 ACK: ack[winner]=1 for exactly one cycle, q shows the new value, then go to IDLE unconditionally.
REQ-022 Latency: req sampled at edge e0 -> grant in cycle e0..e1 -> q updated at e1 -> ack in cycle e1..e2 -> IDLE after e2; minimum 3 cycles per write.
REQ-023 req bits still high in IDLE after ack SHALL be treated as new requests (requesters drop req on ack).
REQ-024 clr and req changes outside IDLE SHALL NOT alter the in-flight transaction; clr outside IDLE is ignored (not queued).
REQ-025 grant and ack SHALL never be nonzero in the same cycle, and SHALL never have more than one bit set.
REQ-026 Changes to non-winning req bits during GRANT/ACK SHALL NOT affect the current transaction.

Reset
REQ-027 While rst=0: state=IDLE, grant=0, ack=0, q=0, qbar=all ones, busy=0, last_id=0, wr_count=0, ptr=0.
REQ-028 rst asserted mid-transaction (GRANT or ACK) SHALL abort it immediately with no write and no ack.
REQ-029 After rst deasserts, the first rising edge SHALL evaluate IDLE rules normally.

Verification
REQ-030 Reset then req=4'b0001, wdata[0]=8'hA5 -> grant=0001 one cycle, q=A5, qbar=5A, ack=0001 one cycle, last_id=0, wr_count=1.
REQ-031 req=4'b1111 held, each requester dropping req on its ack -> grant order 0,1,2,3; final q=wdata[3]; wr_count=4.
REQ-032 After requester 2 writes, req=4'b0101 -> requester 0 granted first (ptr=3 wraps to 0), then requester 2.
REQ-033 IDLE with clr=1 and req=4'b0010 together -> q=00, qbar=FF, no grant that cycle; requester 1 granted next cycle.
REQ-034 req[1] dropped during its GRANT cycle -> no q change, no ack, wr_count unchanged, busy low next cycle.
REQ-035 rst pulled low during ACK -> ack and busy drop immediately, q=00, wr_count=0; 256 completed writes -> wr_count wraps to 0.
